// File: rtl/nn_ctrl_pkg.sv
// rtl/nn_ctrl_pkg.sv - shared types, register map and bit indices for nn_infer_ctrl
// Contents: FSM state enum, 5-bit register addresses, feature count,
// CTRL/STATUS bit positions and a byte-enable merge helper.
package nn_ctrl_pkg;

  localparam int NUM_FEATURES = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_CAPTURE = 2'd3
  } nn_state_e;

  localparam logic [4:0] FEAT_BASE = 5'd0;
  localparam logic [4:0] CTRL      = 5'd16;
  localparam logic [4:0] STATUS    = 5'd17;
  localparam logic [4:0] SCORE1    = 5'd18;
  localparam logic [4:0] SCORE2    = 5'd19;
  localparam logic [4:0] CLASS     = 5'd20;
  localparam logic [4:0] COUNT     = 5'd21;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_IE_BIT      = 1;
  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_DONE_BIT    = 1;
  localparam int STAT_OVERRUN_BIT = 2;

  // Replace only the bytes whose enable bit is set.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/nn_infer_ctrl_float_gt.sv
// rtl/nn_infer_ctrl_float_gt.sv - combinational IEEE-754 single "a greater than b"
// Ports: a, b (in, 32) operands; a_gt_b (out, 1) high when a > b.
// NaN operands are not expected from the datapath; +0 and -0 compare equal.
module float_gt (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        a_gt_b
);

  logic [30:0] mag_a;
  logic [30:0] mag_b;

  assign mag_a = a[30:0];
  assign mag_b = b[30:0];

  // Exponent sits above the mantissa, so an unsigned compare of the
  // magnitude field orders by exponent first, then mantissa.
  always_comb begin
    a_gt_b = 1'b0;
    if ((mag_a == '0) && (mag_b == '0)) begin
      a_gt_b = 1'b0;
    end else if (a[31] != b[31]) begin
      a_gt_b = ~a[31];
    end else if (!a[31]) begin
      a_gt_b = (mag_a > mag_b);
    end else begin
      a_gt_b = (mag_a < mag_b);
    end
  end

endmodule

// File: rtl/nn_infer_ctrl.sv
// rtl/nn_infer_ctrl.sv - Avalon-MM register front end and sequencer for an inference datapath
// Ports: CLK, RESET (sync, active-low); AVL_* zero-wait-state slave;
// NN_X 16 float features out; NN_O1/NN_O2 class scores in; BUSY; IRQ.
// Optional macro NN_INFER_CTRL_IRQ_EN enables IRQ and the CTRL.IE bit.
module nn_infer_ctrl
  import nn_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         AVL_READ,
  input  logic         AVL_WRITE,
  input  logic         AVL_CS,
  input  logic [3:0]   AVL_BYTE_EN,
  input  logic [4:0]   AVL_ADDR,
  input  logic [31:0]  AVL_WRITEDATA,
  output logic [31:0]  AVL_READDATA,
  output logic [511:0] NN_X,
  input  logic [31:0]  NN_O1,
  input  logic [31:0]  NN_O2,
  output logic         BUSY,
  output logic         IRQ
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  nn_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] feat_q   [NUM_FEATURES];
  logic [31:0] feat_d   [NUM_FEATURES];
  logic [31:0] shadow_q [NUM_FEATURES];
  logic [31:0] shadow_d [NUM_FEATURES];
  logic [31:0] score1_q, score1_d;
  logic [31:0] score2_q, score2_d;
  logic [31:0] count_q, count_d;
  logic        class_q, class_d;
  logic        ie_q, ie_d;
  logic        done_q, done_d;
  logic        overrun_q, overrun_d;

  logic        wr_en;
  logic        ctrl_wr;
  logic        start_req;
  logic        o1_gt_o2;
  logic        unused_read;

  // Reads are decoded from the address alone, so the read strobe is not needed.
  assign unused_read = AVL_READ;

  assign wr_en     = AVL_CS & AVL_WRITE;
  assign ctrl_wr   = wr_en && (AVL_ADDR == CTRL) && AVL_BYTE_EN[0];
  assign start_req = ctrl_wr && AVL_WRITEDATA[CTRL_START_BIT];
  assign BUSY      = (state_q != ST_IDLE);

  float_gt u_float_gt (
    .a      (NN_O1),
    .b      (NN_O2),
    .a_gt_b (o1_gt_o2)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    feat_d    = feat_q;
    shadow_d  = shadow_q;
    score1_d  = score1_q;
    score2_d  = score2_q;
    count_d   = count_q;
    class_d   = class_q;
    ie_d      = ie_q;
    done_d    = done_q;
    overrun_d = overrun_q;

    // Feature registers stay writable while busy; only LOAD samples them.
    if (wr_en && !AVL_ADDR[4]) begin
      feat_d[AVL_ADDR[3:0]] = be_merge(feat_q[AVL_ADDR[3:0]], AVL_WRITEDATA, AVL_BYTE_EN);
    end

`ifdef NN_INFER_CTRL_IRQ_EN
    if (ctrl_wr) begin
      ie_d = AVL_WRITEDATA[CTRL_IE_BIT];
    end
`endif

    if (wr_en && (AVL_ADDR == STATUS) && AVL_BYTE_EN[0]) begin
      if (AVL_WRITEDATA[STAT_DONE_BIT])    done_d    = 1'b0;
      if (AVL_WRITEDATA[STAT_OVERRUN_BIT]) overrun_d = 1'b0;
    end

    if (start_req && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d = ST_LOAD;
          done_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        shadow_d = feat_q;
        cnt_d    = SETTLE_LOAD;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_CAPTURE: begin
        score1_d = NN_O1;
        score2_d = NN_O2;
        class_d  = ~o1_gt_o2;
        count_d  = count_q + 32'd1;
        // Assigned after the STATUS clear so a same-cycle clear loses.
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      score1_q  <= '0;
      score2_q  <= '0;
      count_q   <= '0;
      class_q   <= 1'b0;
      ie_q      <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_FEATURES; i++) begin
        feat_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      score1_q  <= score1_d;
      score2_q  <= score2_d;
      count_q   <= count_d;
      class_q   <= class_d;
      ie_q      <= ie_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      feat_q    <= feat_d;
      shadow_q  <= shadow_d;
    end
  end

  always_comb begin
    NN_X = '0;
    for (int i = 0; i < NUM_FEATURES; i++) begin
      NN_X[32*i +: 32] = shadow_q[i];
    end
  end

  always_comb begin
    AVL_READDATA = '0;
    if (!AVL_ADDR[4]) begin
      AVL_READDATA = feat_q[AVL_ADDR[3:0]];
    end else begin
      case (AVL_ADDR)
        CTRL:    AVL_READDATA = {30'd0, ie_q, 1'b0};
        STATUS:  AVL_READDATA = {29'd0, overrun_q, done_q, BUSY};
        SCORE1:  AVL_READDATA = score1_q;
        SCORE2:  AVL_READDATA = score2_q;
        CLASS:   AVL_READDATA = {31'd0, class_q};
        COUNT:   AVL_READDATA = count_q;
        default: AVL_READDATA = '0;
      endcase
    end
  end

`ifdef NN_INFER_CTRL_IRQ_EN
  assign IRQ = ie_q & done_q;
`else
  assign IRQ = 1'b0;
`endif

endmodule

// File: tb/tb_nn_infer_ctrl.sv
// tb/tb_nn_infer_ctrl.sv - randomized self-checking bench for nn_infer_ctrl
module tb_nn_infer_ctrl;

  localparam int SETTLE = 8;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         AVL_READ = 1'b0;
  logic         AVL_WRITE = 1'b0;
  logic         AVL_CS = 1'b0;
  logic [3:0]   AVL_BYTE_EN = 4'h0;
  logic [4:0]   AVL_ADDR = 5'd0;
  logic [31:0]  AVL_WRITEDATA = 32'd0;
  logic [31:0]  AVL_READDATA;
  logic [511:0] NN_X;
  logic [31:0]  NN_O1 = 32'd0;
  logic [31:0]  NN_O2 = 32'd0;
  logic         BUSY;
  logic         IRQ;

  nn_infer_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .AVL_READ      (AVL_READ),
    .AVL_WRITE     (AVL_WRITE),
    .AVL_CS        (AVL_CS),
    .AVL_BYTE_EN   (AVL_BYTE_EN),
    .AVL_ADDR      (AVL_ADDR),
    .AVL_WRITEDATA (AVL_WRITEDATA),
    .AVL_READDATA  (AVL_READDATA),
    .NN_X          (NN_X),
    .NN_O1         (NN_O1),
    .NN_O2         (NN_O2),
    .BUSY          (BUSY),
    .IRQ           (IRQ)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_feat   [16];
  logic [31:0] m_shadow [16];
  logic [31:0] m_score1, m_score2, m_count;
  logic        m_class, m_done, m_overrun, m_ie;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_feat[i]   = 32'd0;
      m_shadow[i] = 32'd0;
    end
    m_score1 = 0; m_score2 = 0; m_count = 0;
    m_class = 0; m_done = 0; m_overrun = 0; m_ie = 0;
  endfunction

  // Signed ordering key: sign-magnitude float mapped onto a number line.
  function automatic longint fkey(input logic [31:0] f);
    longint mag;
    mag = longint'(f[30:0]);
    return f[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] rand_float();
    logic [31:0] r;
    r = $urandom;
    if (r[30:23] == 8'hFF) r[30] = 1'b0;
    if ($urandom_range(0, 7) == 0) r[30:0] = 31'd0;
    return r;
  endfunction

  task automatic do_reset();
    RESET = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    RESET = 1'b1;
    model_reset();
  endtask

  // Drives one write for exactly one clock edge; returns 1ns after that edge.
  task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] be);
    AVL_ADDR = addr; AVL_WRITEDATA = data; AVL_BYTE_EN = be;
    AVL_CS = 1'b1; AVL_WRITE = 1'b1;
    @(posedge CLK); #1;
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;
    if (addr < 5'd16) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) m_feat[addr][8*b +: 8] = data[8*b +: 8];
    end
`ifdef NN_INFER_CTRL_IRQ_EN
    if (addr == 5'd16 && be[0]) m_ie = data[1];
`endif
    if (addr == 5'd17 && be[0]) begin
      if (data[1]) m_done = 1'b0;
      if (data[2]) m_overrun = 1'b0;
    end
  endtask

  task automatic do_read(input logic [4:0] addr, output logic [31:0] data);
    @(posedge CLK); #2;
    AVL_ADDR = addr; AVL_CS = 1'b1; AVL_READ = 1'b1;
    #1;
    data = AVL_READDATA;
    AVL_CS = 1'b0; AVL_READ = 1'b0;
  endtask

  task automatic check_results(input string tag);
    logic [31:0] rd;
    do_read(5'd18, rd); chk({tag, "_score1"}, rd, m_score1);
    do_read(5'd19, rd); chk({tag, "_score2"}, rd, m_score2);
    do_read(5'd20, rd); chk({tag, "_class"},  rd, {31'd0, m_class});
    do_read(5'd21, rd); chk({tag, "_count"},  rd, m_count);
    do_read(5'd17, rd); chk({tag, "_status"}, rd, {29'd0, m_overrun, m_done, 1'b0});
    chk({tag, "_irq"}, {31'd0, IRQ}, {31'd0, m_ie & m_done});
    for (int i = 0; i < 16; i++) chk({tag, "_nnx"}, NN_X[32*i +: 32], m_shadow[i]);
  endtask

  // Model of one inference: shadow captures FEAT, scores/class latch at the end.
  function automatic void model_capture(input logic [31:0] o1, input logic [31:0] o2);
    m_score1 = o1;
    m_score2 = o2;
    m_class  = (fkey(o1) > fkey(o2)) ? 1'b0 : 1'b1;
    m_count  = m_count + 1;
    m_done   = 1'b1;
  endfunction

  task automatic run_infer(input string tag, input logic [31:0] o1, input logic [31:0] o2);
    int n;
    NN_O1 = o1; NN_O2 = o2;
    do_write(5'd16, {30'd0, m_ie, 1'b1}, 4'hF);
    m_shadow = m_feat;
    m_done   = 1'b0;
    n = 0;
    while (BUSY === 1'b1 && n < 400) begin
      n++;
      if (n == 2) chk({tag, "_nnx0_after_load"}, NN_X[31:0], m_shadow[0]);
      @(posedge CLK); #1;
    end
    chk({tag, "_busy_len"}, n, SETTLE + 2);
    model_capture(o1, o2);
    check_results(tag);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (BUSY === 1'b1 && n < 400) begin
      n++;
      @(posedge CLK); #1;
    end
    if (n >= 400) chk({tag, "_idle_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] old5;
    logic [31:0] cnt_before;

    model_reset();
    do_reset();

    // Reset state
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_irq",  {31'd0, IRQ},  32'd0);
    chk("rst_nnx",  NN_X[31:0], 32'd0);
    do_read(5'd17, rd); chk("rst_status", rd, 32'd0);
    do_read(5'd21, rd); chk("rst_count",  rd, 32'd0);
    do_read(5'd16, rd); chk("rst_ctrl",   rd, 32'd0);

    // Byte-enable merge onto a zero register
    do_write(5'd2, 32'hAABBCCDD, 4'b0010);
    do_read(5'd2, rd);
    chk("be_merge", rd, 32'h0000CC00);
    chk("be_merge_model", rd, m_feat[2]);

    // Unmapped addresses read 0 and ignore writes
    do_write(5'd25, 32'hFFFFFFFF, 4'hF);
    do_read(5'd25, rd); chk("unmapped", rd, 32'd0);

    // Basic inference
    do_write(5'd0, 32'h3F800000, 4'hF);
    run_infer("basic", 32'h40000000, 32'h3F800000);
    chk("basic_count1", m_count, 32'd1);
    run_infer("neg",   32'hBF800000, 32'hC0000000);
    run_infer("tie",   32'h3F800000, 32'h3F800000);
    run_infer("zeros", 32'h80000000, 32'h00000000);

    // START during SETTLE plus FEAT write while busy
    do_write(5'd5, 32'hCAFEF00D, 4'hF);
    run_infer("pre_ovr", 32'h00000001, 32'h00000002);
    old5 = m_shadow[5];
    cnt_before = m_count;
    NN_O1 = 32'h41000000; NN_O2 = 32'hC1000000;
    do_write(5'd16, {30'd0, m_ie, 1'b1}, 4'hF);
    m_shadow = m_feat;
    m_done   = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    do_write(5'd16, {30'd0, m_ie, 1'b1}, 4'hF);
    m_overrun = 1'b1;
    do_write(5'd5, 32'h12345678, 4'hF);
    chk("ovr_nnx5_busy", NN_X[191:160], old5);
    wait_idle("ovr");
    model_capture(32'h41000000, 32'hC1000000);
    chk("ovr_single_capture", m_count, cnt_before + 1);
    check_results("ovr");
    repeat (12) @(posedge CLK);
    #1;
    chk("ovr_no_rerun", {31'd0, BUSY}, 32'd0);
    do_read(5'd21, rd); chk("ovr_count_stable", rd, m_count);
    do_write(5'd17, 32'h4, 4'h1);
    do_read(5'd17, rd); chk("ovr_cleared", rd, {29'd0, m_overrun, m_done, 1'b0});
    run_infer("post_ovr", 32'h3F000000, 32'h3F000001);

    // DONE clear in the CAPTURE cycle: set wins
    NN_O1 = 32'h40400000; NN_O2 = 32'h40000000;
    do_write(5'd16, {30'd0, m_ie, 1'b1}, 4'hF);
    m_shadow = m_feat;
    repeat (SETTLE + 1) begin
      @(posedge CLK); #1;
    end
    do_write(5'd17, 32'h2, 4'h1);
    model_capture(32'h40400000, 32'h40000000);
    check_results("done_race");

    // Interrupt enable
    do_write(5'd16, 32'h2, 4'hF);
    do_read(5'd16, rd); chk("ie_readback", rd, {30'd0, m_ie, 1'b0});
    run_infer("irq", 32'h3F800000, 32'h40000000);
    do_write(5'd17, 32'h2, 4'h1);
    chk("irq_cleared", {31'd0, IRQ}, 32'd0);

    // Randomized traffic
    for (int it = 0; it < 20; it++) begin
      int nw;
      logic [31:0] o1, o2;
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++)
        do_write(5'($urandom_range(0, 15)), $urandom, 4'($urandom_range(1, 15)));
      do_read(5'($urandom_range(0, 15)), rd);
      chk("rand_feat_rd", rd, m_feat[AVL_ADDR[3:0]]);
      o1 = rand_float();
      case ($urandom_range(0, 3))
        0:       o2 = o1;
        1:       o2 = {~o1[31], o1[30:0]};
        default: o2 = rand_float();
      endcase
      run_infer("rand", o1, o2);
    end

    // Reset in the middle of SETTLE
    do_write(5'd16, {30'd0, m_ie, 1'b1}, 4'hF);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
    model_reset();
    chk("midrst_busy", {31'd0, BUSY}, 32'd0);
    chk("midrst_nnx0", NN_X[31:0], 32'd0);
    chk("midrst_irq",  {31'd0, IRQ}, 32'd0);
    do_read(5'd17, rd); chk("midrst_status", rd, 32'd0);
    do_read(5'd21, rd); chk("midrst_count",  rd, 32'd0);
    RESET = 1'b1;
    repeat (SETTLE + 6) @(posedge CLK);
    #1;
    chk("midrst_no_capture_busy", {31'd0, BUSY}, 32'd0);
    do_read(5'd21, rd); chk("midrst_no_capture_count", rd, 32'd0);
    do_read(5'd0, rd);  chk("midrst_feat0", rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
